sim_exit_ctrl: RTL and testbench

Memory-mapped simulation exit and watchdog controller on the SoC peripheral bus, directly upstream of the simulation top. Firmware writes a return code and an exit strobe; the block produces the `exit_valid_o`/`exit_value_o` pair the top level samples to print EXIT SUCCESS/FAILURE and finish. A programmable cycle watchdog forces an exit with a fixed code if firmware stops kicking it, so hung tests terminate without relying on a `maxcycles` plusarg.

---
 rtl/sim_exit_ctrl.sv | 155 +++++++++++++++
 tb/tb_sim_exit_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_exit_ctrl.sv
// sim_exit_ctrl: memory-mapped simulation exit register block with a
// cycle watchdog that forces an exit with a fixed code when not kicked.
module sim_exit_ctrl #(
  parameter logic [31:0] WDOG_DEFAULT = 32'd0,
  parameter logic [31:0] TIMEOUT_CODE = 32'hDEAD_0001
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        timeout_o
);

  localparam logic [1:0] REG_EXIT_VALUE = 2'd0;
  localparam logic [1:0] REG_EXIT_CTRL  = 2'd1;
  localparam logic [1:0] REG_WDOG_LIMIT = 2'd2;
  localparam logic [1:0] REG_WDOG_KICK  = 2'd3;

  // Merge new write data into an old word, one byte lane per enable bit.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0] exit_value;
  logic        exit_valid;
  logic        timeout;
  logic [31:0] wdog_limit;
  logic [31:0] wdog_cnt;
  logic        rvalid;
  logic [31:0] rdata;

  logic        wr_value;
  logic        sw_exit;
  logic        wr_limit;
  logic        kick;
  logic        wdog_en;
  logic        expire;
  logic [31:0] rd_mux;

  assign gnt_o        = req_i;
  assign rvalid_o     = rvalid;
  assign rdata_o      = rdata;
  assign exit_valid_o = exit_valid;
  assign exit_value_o = exit_value;
  assign timeout_o    = timeout;

  // Decode the current request and watchdog expiry; a kick or limit write
  // suppresses an expiry due in the same cycle.
  always_comb begin
    wr_value = 1'b0;
    sw_exit  = 1'b0;
    wr_limit = 1'b0;
    kick     = 1'b0;
    rd_mux   = 32'd0;
    if (req_i && we_i) begin
      case (addr_i[3:2])
        REG_EXIT_VALUE: wr_value = 1'b1;
        REG_EXIT_CTRL:  sw_exit  = be_i[0] & wdata_i[0];
        REG_WDOG_LIMIT: begin
          wr_limit = 1'b1;
          kick     = 1'b1;
        end
        REG_WDOG_KICK:  kick = 1'b1;
        default:        kick = 1'b0;
      endcase
    end else begin
      wr_value = 1'b0;
    end
    case (addr_i[3:2])
      REG_EXIT_VALUE: rd_mux = exit_value;
      REG_EXIT_CTRL:  rd_mux = {30'd0, timeout, exit_valid};
      REG_WDOG_LIMIT: rd_mux = wdog_limit;
      REG_WDOG_KICK:  rd_mux = wdog_cnt;
      default:        rd_mux = 32'd0;
    endcase
    wdog_en = (wdog_limit != 32'd0) && !exit_valid;
    expire  = wdog_en && (wdog_cnt == (wdog_limit - 32'd1)) && !kick;
  end

  // Exit state: software exit beats watchdog expiry; frozen once exited.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exit_valid <= 1'b0;
      timeout    <= 1'b0;
      exit_value <= 32'd0;
    end else if (!exit_valid) begin
      if (sw_exit) begin
        exit_valid <= 1'b1;
      end else if (expire) begin
        exit_valid <= 1'b1;
        timeout    <= 1'b1;
        exit_value <= TIMEOUT_CODE;
      end else if (wr_value) begin
        exit_value <= apply_be(exit_value, wdata_i, be_i);
      end else begin
        exit_value <= exit_value;
      end
    end else begin
      exit_value <= exit_value;
    end
  end

  // Watchdog limit and counter; the counter holds on the expiry edge and
  // whenever the watchdog is disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_limit <= WDOG_DEFAULT;
      wdog_cnt   <= 32'd0;
    end else begin
      if (wr_limit) begin
        wdog_limit <= apply_be(wdog_limit, wdata_i, be_i);
      end else begin
        wdog_limit <= wdog_limit;
      end
      if (kick) begin
        wdog_cnt <= 32'd0;
      end else if (wdog_en && !expire) begin
        wdog_cnt <= wdog_cnt + 32'd1;
      end else begin
        wdog_cnt <= wdog_cnt;
      end
    end
  end

  // Bus response: one rvalid per grant, read data captured at the grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid <= 1'b0;
      rdata  <= 32'd0;
    end else begin
      rvalid <= req_i;
      rdata  <= (req_i && !we_i) ? rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_sim_exit_ctrl.sv
// Directed self-checking bench for sim_exit_ctrl.
module tb_sim_exit_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        exit_valid;
  logic [31:0] exit_value;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  sim_exit_ctrl dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .exit_valid_o(exit_valid), .exit_value_o(exit_value),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    tick();
    req = 1'b0; we = 1'b0; be = 4'h0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic v, output logic [31:0] d);
    req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
    tick();
    v = rvalid; d = rdata;
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if ({rvalid, rdata, exit_valid, exit_value, timeout} !== 67'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%b rd=%h ev=%b val=%h to=%b, want all 0",
               rvalid, rdata, exit_valid, exit_value, timeout);
    end
  endtask

  task automatic test_normal_exit();
    logic v; logic [31:0] d;
    test_reset();
    do_write(32'h0, 32'h0, 4'hF);
    do_write(32'h4, 32'h1, 4'hF);
    checks++;
    if ({exit_valid, timeout, exit_value} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL normal_exit: got ev=%b to=%b val=%h, want 1 0 00000000", exit_valid, timeout, exit_value);
    end
    do_read(32'h4, v, d);
    checks++;
    if ({v, d} !== {1'b1, 32'h1}) begin
      errors++;
      $display("FAIL normal_ctrl_read: got v=%b d=%h, want 1 00000001", v, d);
    end
  endtask

  task automatic test_byte_enable();
    test_reset();
    do_write(32'h0, 32'h1234_5678, 4'b0011);
    do_write(32'h4, 32'h1, 4'b1110);
    checks++;
    if (exit_valid !== 1'b0) begin
      errors++;
      $display("FAIL ctrl_be0_clear: got ev=%b, want 0", exit_valid);
    end
    do_write(32'h4, 32'h1, 4'b0001);
    checks++;
    if ({exit_valid, exit_value} !== {1'b1, 32'h0000_5678}) begin
      errors++;
      $display("FAIL be_exit_value: got ev=%b val=%h, want 1 00005678", exit_valid, exit_value);
    end
    do_write(32'h0, 32'hFF, 4'hF);
    checks++;
    if (exit_value !== 32'h0000_5678) begin
      errors++;
      $display("FAIL frozen_value: got %h, want 00005678", exit_value);
    end
  endtask

  task automatic test_watchdog();
    logic v; logic [31:0] d;
    test_reset();
    do_write(32'h8, 32'd5, 4'hF);        // edge k
    repeat (4) tick();                  // edges k+1..k+4
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL wdog_early: got to=%b at k+4, want 0", timeout);
    end
    tick();                             // edge k+5
    checks++;
    if ({timeout, exit_valid, exit_value} !== {1'b1, 1'b1, 32'hDEAD_0001}) begin
      errors++;
      $display("FAIL wdog_expire: got to=%b ev=%b val=%h, want 1 1 dead0001", timeout, exit_valid, exit_value);
    end
    do_read(32'hC, v, d);
    checks++;
    if ({v, d} !== {1'b1, 32'd4}) begin
      errors++;
      $display("FAIL wdog_cnt_read: got v=%b d=%0d, want 1 4", v, d);
    end
  endtask

  task automatic test_kick();
    logic v; logic [31:0] d;
    test_reset();
    do_write(32'h8, 32'd5, 4'hF);        // edge k
    repeat (3) tick();                  // edges k+1..k+3
    do_write(32'hC, 32'd0, 4'hF);        // kick at edge k+4
    do_read(32'hC, v, d);               // edge k+5
    checks++;
    if ({v, d} !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL kick_cnt0: got v=%b d=%0d, want 1 0", v, d);
    end
    do_read(32'hC, v, d);               // edge k+6
    checks++;
    if (d !== 32'd1) begin
      errors++;
      $display("FAIL kick_cnt1: got %0d, want 1", d);
    end
    repeat (2) tick();                  // edges k+7, k+8
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL kick_early: got to=%b at k+8, want 0", timeout);
    end
    tick();                             // edge k+9
    checks++;
    if ({timeout, exit_valid} !== 2'b11) begin
      errors++;
      $display("FAIL kick_expire: got to=%b ev=%b at k+9, want 1 1", timeout, exit_valid);
    end
  endtask

  task automatic test_kick_race();
    logic v; logic [31:0] d;
    test_reset();
    do_write(32'h8, 32'd3, 4'hF);        // edge k
    repeat (2) tick();                  // edges k+1, k+2
    do_write(32'hC, 32'd0, 4'hF);        // kick on expiry edge k+3
    checks++;
    if ({timeout, exit_valid} !== 2'b00) begin
      errors++;
      $display("FAIL kick_race: got to=%b ev=%b, want 0 0", timeout, exit_valid);
    end
    do_read(32'hC, v, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL kick_race_cnt: got %0d, want 0", d);
    end
  endtask

  task automatic test_exit_race();
    test_reset();
    do_write(32'h0, 32'hCAFE_0042, 4'hF);
    do_write(32'h8, 32'd3, 4'hF);        // edge k
    repeat (2) tick();                  // edges k+1, k+2
    do_write(32'h4, 32'h1, 4'h1);        // exit on expiry edge k+3
    checks++;
    if ({exit_valid, timeout, exit_value} !== {1'b1, 1'b0, 32'hCAFE_0042}) begin
      errors++;
      $display("FAIL exit_race: got ev=%b to=%b val=%h, want 1 0 cafe0042", exit_valid, timeout, exit_value);
    end
    repeat (3) tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL exit_race_late: got to=%b, want 0", timeout);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [4];
    test_reset();
    do_write(32'h0, 32'h1122_3344, 4'hF);
    do_write(32'h8, 32'd100, 4'hF);     // edge a, counter 0
    exp_data[0] = 32'h1122_3344;
    exp_data[1] = 32'h0;
    exp_data[2] = 32'd100;
    exp_data[3] = 32'd3;                // counter during cycle before a+4
    req = 1'b1; we = 1'b0; be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      addr = 32'hF000_0000 | (i * 4);   // upper bits ignored
      tick();
      checks++;
      if ({rvalid, rdata} !== {1'b1, exp_data[i]}) begin
        errors++;
        $display("FAIL b2b_read%0d: got v=%b d=%h, want 1 %h", i, rvalid, rdata, exp_data[i]);
      end
    end
    req = 1'b0;
    tick();
    checks++;
    if ({rvalid, rdata} !== 33'd0) begin
      errors++;
      $display("FAIL b2b_idle: got v=%b d=%h, want 0 0", rvalid, rdata);
    end
  endtask

  task automatic test_reset_midflight();
    logic v; logic [31:0] d;
    do_write(32'h4, 32'h1, 4'h1);       // exited with a nonzero value
    req = 1'b1; we = 1'b0; addr = 32'h0;
    tick();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({rvalid, rdata, exit_valid, exit_value, timeout} !== 67'd0 || gnt !== req) begin
      errors++;
      $display("FAIL reset_midflight: got rv=%b rd=%h ev=%b val=%h to=%b gnt=%b, want 0s gnt=%b",
               rvalid, rdata, exit_valid, exit_value, timeout, gnt, req);
    end
    req = 1'b0;
    tick();
    rst = 1'b0;
    do_read(32'h8, v, d);
    checks++;
    if ({v, d} !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL reset_limit: got v=%b d=%h, want 1 00000000", v, d);
    end
  endtask

  initial begin
    test_reset();
    test_normal_exit();
    test_byte_enable();
    test_watchdog();
    test_kick();
    test_kick_race();
    test_exit_race();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
